mem_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single-port 64x32 memory between NUM_REQ requesters.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_rr_arbiter_if.sv | 35 +++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/mem_rr_arbiter.sv | 79 +++++++
 tb/tb_mem_rr_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
// Holds the read-return tag layout and the out-of-range helper.
package mem_arb_pkg;

    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_DW      = 32;
    localparam int DEF_AW      = 8;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_RD_LAT  = 1;
    localparam int ID_W        = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } rd_tag_t;

    function automatic logic oob(input logic [31:0] addr,
                                 input int unsigned depth);
        return addr >= depth;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Client command/return bus plus the memory-facing port.
// slave = arbiter side, master = clients/memory side.
interface mem_rr_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    we;
    logic [NUM_REQ*AW-1:0] addr;
    logic [NUM_REQ*DW-1:0] wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [DW-1:0]         rd_data;
    logic                  rd_err;
    logic                  mem_write_enable;
    logic [AW-1:0]         mem_address;
    logic [DW-1:0]         mem_data_in;
    logic [DW-1:0]         mem_data_out;

    modport slave (
        input  req, we, addr, wdata, mem_data_out,
        output gnt, rd_valid, rd_data, rd_err,
        output mem_write_enable, mem_address, mem_data_in
    );

    modport master (
        output req, we, addr, wdata, mem_data_out,
        input  gnt, rd_valid, rd_data, rd_err,
        input  mem_write_enable, mem_address, mem_data_in
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first request at or after the pointer wins.
// Owns the priority pointer, which moves past each winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_id,
    output logic               any
);

    logic [IDW-1:0] ptr;
    int             idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && !rst && req[idx]) begin
                any    = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
        if (any) gnt = NUM_REQ'(1) << gnt_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any) begin
            if (gnt_id == IDW'(NUM_REQ - 1)) ptr <= '0;
            else                             ptr <= gnt_id + IDW'(1);
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Shares one single-port memory between NUM_REQ clients, one command per cycle.
// Registers the memory command and steers read data back by tag.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DW         = DEF_DW,
    parameter int AW         = DEF_AW,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MEM_RD_LAT = DEF_RD_LAT
) (
    input logic             clk,
    input logic             rst,
    mem_rr_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gid;
    logic               any;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               sel_we;
    logic               sel_oob;

    rd_tag_t iss_tag;
    rd_tag_t pipe [MEM_RD_LAT];
    rd_tag_t tail;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .gnt    (gnt),
        .gnt_id (gid),
        .any    (any)
    );

    assign bus.gnt   = gnt;
    assign sel_addr  = bus.addr[int'(gid)*AW +: AW];
    assign sel_wdata = bus.wdata[int'(gid)*DW +: DW];
    assign sel_we    = bus.we[gid];
    assign sel_oob   = oob(32'(sel_addr), DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_write_enable <= 1'b0;
            bus.mem_address      <= '0;
            bus.mem_data_in      <= '0;
            iss_tag              <= '0;
        end else begin
            bus.mem_write_enable <= any & sel_we & ~sel_oob;
            if (any) begin
                bus.mem_address <= sel_addr;
                bus.mem_data_in <= sel_wdata;
            end
            iss_tag.valid <= any & ~sel_we;
            iss_tag.id    <= ID_W'(gid);
            iss_tag.err   <= sel_oob;
        end
    end

    // Tag travels alongside the memory read so the return lines up with data_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MEM_RD_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= iss_tag;
            for (int k = 1; k < MEM_RD_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign tail         = pipe[MEM_RD_LAT-1];
    assign bus.rd_valid = tail.valid ? (NUM_REQ'(1) << tail.id) : '0;
    assign bus.rd_err   = tail.valid & tail.err;
    assign bus.rd_data  = (tail.valid & ~tail.err) ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a cycle-level reference model.
// A 64x32 synchronous RAM model sits on the memory port.
module tb_mem_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.NUM_REQ(2), .DW(32), .AW(8)) bus ();

    mem_rr_arbiter #(.NUM_REQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [64] = '{default: 32'h0};

    always @(posedge clk) begin
        if (bus.mem_write_enable) ram[bus.mem_address[5:0]] <= bus.mem_data_in;
        bus.mem_data_out <= ram[bus.mem_address[5:0]];
    end

    typedef struct {
        int          due;
        int          id;
        bit          err;
        logic [31:0] data;
    } ret_t;

    ret_t        rq[$];
    logic [31:0] model_mem [64] = '{default: 32'h0};
    int          cyc   = 0;
    int          ptr   = 0;
    bit          armed = 1'b0;
    logic        e_mwe;
    logic [7:0]  e_maddr;
    logic [31:0] e_mdata;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(logic [1:0] r, int p);
        for (int k = 0; k < 2; k++)
            if (r[(p + k) % 2]) return (p + k) % 2;
        return -1;
    endfunction

    // Model: spec-level view of one cycle, checked mid-cycle.
    task automatic model_step();
        logic [1:0]  erv;
        logic        eerr;
        logic [31:0] edat;
        logic [1:0]  egnt;
        logic [7:0]  a;
        logic [31:0] d;
        int          g;
        ret_t        e;
        g = rst ? -1 : pick(bus.req, ptr);
        if (armed) begin
            chk("mem_we", 64'(bus.mem_write_enable), 64'(e_mwe));
            chk("mem_addr", 64'(bus.mem_address), 64'(e_maddr));
            chk("mem_din", 64'(bus.mem_data_in), 64'(e_mdata));
            erv  = 2'b00;
            eerr = 1'b0;
            edat = 32'h0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e         = rq.pop_front();
                erv[e.id] = 1'b1;
                eerr      = e.err;
                edat      = e.err ? 32'h0 : e.data;
            end
            chk("rd_valid", 64'(bus.rd_valid), 64'(erv));
            chk("rd_err", 64'(bus.rd_err), 64'(eerr));
            chk("rd_data", 64'(bus.rd_data), 64'(edat));
            egnt = (g >= 0) ? (2'b01 << g) : 2'b00;
            chk("gnt", 64'(bus.gnt), 64'(egnt));
        end
        if (rst) begin
            e_mwe   = 1'b0;
            e_maddr = 8'h0;
            e_mdata = 32'h0;
            rq.delete();
            ptr   = 0;
            armed = 1'b1;
        end else if (g >= 0) begin
            a       = bus.addr[g*8 +: 8];
            d       = bus.wdata[g*32 +: 32];
            e_mwe   = bus.we[g] && (a < 8'd64);
            e_maddr = a;
            e_mdata = d;
            if (!bus.we[g])
                rq.push_back('{cyc + 2, g, a >= 8'd64, (a < 8'd64) ? model_mem[a[5:0]] : 32'h0});
            else if (a < 8'd64)
                model_mem[a[5:0]] = d;
            ptr = (g + 1) % 2;
        end else begin
            e_mwe = 1'b0;
        end
        cyc++;
    endtask

    task automatic cyc_chk();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run(int n);
        repeat (n) begin
            cyc_chk();
            adv();
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.req   = 2'b00;
        bus.we    = 2'b00;
        bus.addr  = 16'h0;
        bus.wdata = 64'h0;
        run(3);
        rst = 1'b0;

        // single write
        bus.req = 2'b01; bus.we = 2'b01;
        bus.addr[7:0] = 8'd5; bus.wdata[31:0] = 32'hDEADBEEF;
        cyc_chk(); chk("t1_gnt", 64'(bus.gnt), 64'h1);
        adv();
        bus.req = 2'b00;
        cyc_chk();
        chk("t1_mwe", 64'(bus.mem_write_enable), 64'h1);
        chk("t1_maddr", 64'(bus.mem_address), 64'd5);
        chk("t1_mdin", 64'(bus.mem_data_in), 64'hDEADBEEF);
        adv();

        // read back from requester 1
        bus.req = 2'b10; bus.we = 2'b00; bus.addr[15:8] = 8'd5;
        cyc_chk(); chk("t2_gnt", 64'(bus.gnt), 64'h2);
        adv();
        bus.req = 2'b00;
        run(1);
        cyc_chk();
        chk("t2_rv", 64'(bus.rd_valid), 64'h2);
        chk("t2_rdata", 64'(bus.rd_data), 64'hDEADBEEF);
        chk("t2_rerr", 64'(bus.rd_err), 64'h0);
        adv();

        // contention, all reads
        bus.req = 2'b11; bus.we = 2'b00;
        bus.addr[7:0] = 8'd5; bus.addr[15:8] = 8'd6;
        cyc_chk(); chk("t3_gnt0", 64'(bus.gnt), 64'h1);
        adv();
        cyc_chk(); chk("t3_gnt1", 64'(bus.gnt), 64'h2);
        adv();
        run(4);
        bus.req = 2'b00;
        run(2);

        // out-of-range write then read
        bus.req = 2'b01; bus.we = 2'b01;
        bus.addr[7:0] = 8'd225; bus.wdata[31:0] = 32'hFFFFFFFF;
        cyc_chk(); chk("t4_wgnt", 64'(bus.gnt), 64'h1);
        adv();
        bus.req = 2'b00;
        cyc_chk(); chk("t4_mwe", 64'(bus.mem_write_enable), 64'h0);
        adv();
        bus.req = 2'b10; bus.we = 2'b00; bus.addr[15:8] = 8'd225;
        cyc_chk(); chk("t4_rgnt", 64'(bus.gnt), 64'h2);
        adv();
        bus.req = 2'b00;
        run(1);
        cyc_chk();
        chk("t4_rv", 64'(bus.rd_valid), 64'h2);
        chk("t4_rerr", 64'(bus.rd_err), 64'h1);
        chk("t4_rdata", 64'(bus.rd_data), 64'h0);
        adv();

        // reset while a read is in flight
        bus.req = 2'b01; bus.we = 2'b00; bus.addr[7:0] = 8'd5;
        cyc_chk(); chk("t5_gnt", 64'(bus.gnt), 64'h1);
        adv();
        bus.req = 2'b00; rst = 1'b1;
        run(1);
        rst = 1'b0;
        cyc_chk(); chk("t5_rv_n2", 64'(bus.rd_valid), 64'h0);
        adv();
        cyc_chk(); chk("t5_rv_n3", 64'(bus.rd_valid), 64'h0);
        adv();
        bus.req = 2'b11;
        cyc_chk(); chk("t5_gnt_after", 64'(bus.gnt), 64'h1);
        adv();
        bus.req = 2'b00;
        run(3);

        // write then read same address, same requester
        bus.req = 2'b01; bus.we = 2'b01;
        bus.addr[7:0] = 8'd10; bus.wdata[31:0] = 32'h00001234;
        cyc_chk(); chk("t6_wgnt", 64'(bus.gnt), 64'h1);
        adv();
        bus.we = 2'b00;
        cyc_chk(); chk("t6_rgnt", 64'(bus.gnt), 64'h1);
        adv();
        bus.req = 2'b00;
        run(1);
        cyc_chk();
        chk("t6_rv", 64'(bus.rd_valid), 64'h1);
        chk("t6_rdata", 64'(bus.rd_data), 64'h1234);
        adv();
        run(3);

        for (int i = 0; i < 64; i++) chk("ram", 64'(ram[i]), 64'(model_mem[i]));
        chk("ram33", 64'(ram[33]), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
